// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module      : dmem_responder_if
// Description : Data-side request/response bundle between pipeline and dmem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        overflow;
  logic        busy;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_error, overflow, busy
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_error, overflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Word-array data memory with wait states and a one-deep
//               pending request slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int          DEPTH_LOG2  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         ADDR_MSB = DEPTH_LOG2 + 2;
  localparam logic [3:0] WAIT_C   = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        act_q, act_d;
  req_t        pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        ovf_q, ovf_d;

  logic [31:0] mem_q [DEPTH];

  req_t                  req_in;
  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  complete;
  logic                  is_write;
  logic                  unused_bits;

  assign req_in   = '{addr: bus.mem_addr, wdata: bus.mem_wdata, wstrb: bus.mem_wstrb};
  // Below-base addresses wrap to a huge offset, so one upper-bit test covers both bounds.
  assign offset   = act_q.addr - BASE_ADDR;
  assign in_range = (offset[31:ADDR_MSB] == '0);
  assign widx     = offset[ADDR_MSB-1:2];
  assign complete = (state_q == BUSY) && (cnt_q == WAIT_C);
  assign is_write = |act_q.wstrb;

  assign unused_bits = ^{bus.mem_instr, offset[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          act_d   = req_in;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (complete) begin
          cnt_d = '0;
          if (pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = bus.mem_valid;
            if (bus.mem_valid) pend_d = req_in;
          end else if (bus.mem_valid) begin
            act_d = req_in;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (bus.mem_valid) begin
            if (!pend_vld_q) begin
              pend_d     = req_in;
              pend_vld_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && complete && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (act_q.wstrb[b]) mem_q[widx][8*b +: 8] <= act_q.wdata[8*b +: 8];
      end
    end
  end

  // Reset squashes a completion already decoded from state.
  assign bus.mem_ready = complete && !rst;
  assign bus.mem_error = complete && !rst && !in_range;
  assign bus.mem_rdata = (complete && !rst && in_range && !is_write) ? mem_q[widx] : '0;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = (state_q == BUSY);

endmodule

`default_nettype wire
